sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller.sv | 113 +++++++++++
 tb/tb_sram_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage load/store into two 16-bit asynchronous SRAM accesses
// (low half, then high half), followed by a fixed settle period, stalling the pipeline meanwhile.
module sram_controller #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] sram_dq,
    output logic [17:0] sram_addr,
    output logic        sram_we_n,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] WAIT_LAST = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {IDLE, LOW, HIGH, WAIT, DONE} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] wait_cnt_reg, wait_cnt_next;
    logic          op_write_reg, op_write_next;
    logic [16:0]   word_index_reg, word_index_next;
    logic [31:0]   addr_off;
    logic          write_phase;
    logic          unused_addr_bits;

    assign addr_off         = address - BASE_ADDR;
    // Byte lane bits and anything above the 18-bit half-word space are dropped.
    assign unused_addr_bits = ^{addr_off[31:19], addr_off[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            wait_cnt_reg   <= '0;
            op_write_reg   <= 1'b0;
            word_index_reg <= '0;
        end else begin
            state_reg      <= state_next;
            wait_cnt_reg   <= wait_cnt_next;
            op_write_reg   <= op_write_next;
            word_index_reg <= word_index_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        wait_cnt_next   = wait_cnt_reg;
        op_write_next   = op_write_reg;
        word_index_next = word_index_reg;
        case (state_reg)
            IDLE: begin
                wait_cnt_next = '0;
                if (rd_en || wr_en) begin
                    state_next      = LOW;
                    op_write_next   = wr_en;
                    word_index_next = addr_off[18:2];
                end
            end
            LOW:  state_next = HIGH;
            HIGH: begin
                wait_cnt_next = '0;
                state_next    = (WAIT_CYCLES == 0) ? DONE : WAIT;
            end
            WAIT: begin
                if (wait_cnt_reg == WAIT_LAST) begin
                    state_next = DONE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Half gi of read_data is sampled on the edge that ends the state addressing that half.
    for (genvar gi = 0; gi < 2; gi++) begin : g_capture
        localparam state_t CAP_STATE = (gi == 0) ? LOW : HIGH;
        logic [15:0] half_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                half_reg <= '0;
            end else if (!op_write_reg && state_reg == CAP_STATE) begin
                half_reg <= sram_dq;
            end
        end
    end

    assign read_data   = {g_capture[1].half_reg, g_capture[0].half_reg};
    assign write_phase = op_write_reg && (state_reg == LOW || state_reg == HIGH);
    assign sram_we_n   = !write_phase;
    assign sram_addr   = {word_index_reg, state_reg == HIGH};
    assign sram_dq     = write_phase ? ((state_reg == HIGH) ? write_data[31:16] : write_data[15:0])
                                     : 16'bz;
    assign ready       = (state_reg == IDLE && !rd_en && !wr_en) || state_reg == DONE;

    assign sram_ce_n = 1'b0;
    assign sram_oe_n = 1'b0;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: transaction-level expectation queue checked every cycle,
// async SRAM models on the data buses, and a second instance with no wait cycles.
module tb_sram_controller;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        wr_en = 1'b0, rd_en = 1'b0;
    logic [31:0] address = '0, write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n;

    logic        wr_en_b = 1'b0, rd_en_b = 1'b0;
    logic [31:0] address_b = '0, write_data_b = '0;
    logic [31:0] read_data_b;
    logic        ready_b;
    wire  [15:0] sram_dq_b;
    logic [17:0] sram_addr_b;
    logic        sram_we_n_b, sram_ce_n_b, sram_oe_n_b, sram_ub_n_b, sram_lb_n_b;

    sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready), .sram_dq(sram_dq),
        .sram_addr(sram_addr), .sram_we_n(sram_we_n), .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en_b), .rd_en(rd_en_b), .address(address_b),
        .write_data(write_data_b), .read_data(read_data_b), .ready(ready_b), .sram_dq(sram_dq_b),
        .sram_addr(sram_addr_b), .sram_we_n(sram_we_n_b), .sram_ce_n(sram_ce_n_b),
        .sram_oe_n(sram_oe_n_b), .sram_ub_n(sram_ub_n_b), .sram_lb_n(sram_lb_n_b)
    );

    // Asynchronous SRAM models: drive the bus whenever not being written.
    logic [15:0] sram_a [0:1023];
    logic [15:0] mem_b  [0:1023];
    assign sram_dq   = sram_we_n   ? sram_a[sram_addr[9:0]]  : 16'bz;
    assign sram_dq_b = sram_we_n_b ? mem_b[sram_addr_b[9:0]] : 16'bz;
    always @(posedge clk) if (!sram_we_n) sram_a[sram_addr[9:0]] <= sram_dq;

    // Reference model: memory contents and last loaded word.
    logic [15:0] ref_mem [0:1023];
    logic [31:0] model_rd = '0;

    typedef struct {
        bit          ready;
        bit          we_n;
        bit          chk_addr;
        logic [17:0] addr;
        bit          chk_dq;
        logic [15:0] dq;
        bit          chk_rd;
        logic [31:0] rd;
    } exp_t;
    exp_t exp_q[$];

    int cmp_cnt = 0;
    int err_cnt = 0;
    bit cmp_on  = 1'b0;
    int low_run = 0;
    int last_low_run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        cmp_cnt++;
        if (act !== expv) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Build the per-cycle expectations of one access from the access rules.
    task automatic plan(input bit w, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] off;
        logic [17:0] hw;
        logic [9:0]  i0, i1;
        exp_t        e;
        off = a - 32'd1024;
        hw  = {off[18:2], 1'b0};
        i0  = hw[9:0];
        i1  = i0 + 10'd1;
        e.ready = 1'b0; e.we_n = 1'b1; e.chk_addr = 1'b0; e.addr = '0;
        e.chk_dq = 1'b0; e.dq = '0; e.chk_rd = w; e.rd = model_rd;
        exp_q.push_back(e);
        e.we_n = !w; e.chk_addr = 1'b1; e.addr = hw; e.chk_dq = w; e.dq = d[15:0];
        exp_q.push_back(e);
        e.addr = hw | 18'd1; e.dq = d[31:16];
        exp_q.push_back(e);
        e.we_n = 1'b1; e.chk_addr = 1'b0; e.chk_dq = 1'b0;
        for (int k = 0; k < W; k++) exp_q.push_back(e);
        if (w) begin
            ref_mem[i0] = d[15:0];
            ref_mem[i1] = d[31:16];
        end else begin
            model_rd = {ref_mem[i1], ref_mem[i0]};
        end
        e.ready = 1'b1; e.chk_rd = 1'b1; e.rd = model_rd;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("ready", ready, e.ready);
                check("we_n", sram_we_n, e.we_n);
                if (e.chk_addr) check("sram_addr", sram_addr, e.addr);
                if (e.chk_dq)   check("sram_dq", sram_dq, e.dq);
                if (e.chk_rd)   check("read_data", read_data, e.rd);
            end else begin
                check("idle_ready", ready, (rd_en || wr_en) ? 1'b0 : 1'b1);
                check("idle_we_n", sram_we_n, 1'b1);
                check("idle_read_data", read_data, model_rd);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (!ready) low_run++;
            else if (low_run > 0) begin
                last_low_run = low_run;
                low_run = 0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_access(input bit w, input bit r, input logic [31:0] a,
                             input logic [31:0] d, input bit hold);
        @(posedge clk);
        #1;
        wr_en = w; rd_en = r; address = a; write_data = d;
        plan(w, a, d);
        $display("txn wr=%0b rd=%0b addr=%0d data=%h hold=%0b", w, r, a, d, hold);
        repeat (3 + W) @(posedge clk);
        #1;
        if (!hold) begin
            wr_en = 1'b0;
            rd_en = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            sram_a[i]  = 16'(i * 257) ^ 16'hA5A5;
            ref_mem[i] = 16'(i * 257) ^ 16'hA5A5;
            mem_b[i]   = 16'h0;
        end
        sram_a[2] = 16'h5678; ref_mem[2] = 16'h5678;
        sram_a[3] = 16'h1234; ref_mem[3] = 16'h1234;
        mem_b[2]  = 16'h5678;
        mem_b[3]  = 16'h1234;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_ready", ready, 1'b1);
        check("reset_read_data", read_data, 32'h0);
        check("reset_we_n", sram_we_n, 1'b1);
        cmp_on = 1'b1;
        idle(2);

        do_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0);
        idle(1);
        check("wr_lo_stored", sram_a[0], 16'hBEEF);
        check("wr_hi_stored", sram_a[1], 16'hDEAD);
        check("wr_ready_low_cycles", last_low_run, 5);

        do_access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
        check("rd_literal", read_data, 32'h12345678);
        idle(2);

        do_access(1'b1, 1'b1, 32'd1032, 32'h0000FFFF, 1'b0);
        idle(1);
        check("both_rd_unchanged", read_data, 32'h12345678);
        check("both_lo_stored", sram_a[4], 16'hFFFF);
        check("both_hi_stored", sram_a[5], 16'h0000);

        do_access(1'b1, 1'b0, 32'd1036, 32'hCAFEF00D, 1'b1);
        do_access(1'b0, 1'b1, 32'd1036, 32'h0, 1'b0);
        check("b2b_readback", read_data, 32'hCAFEF00D);
        idle(2);

        // Reset pulse in the first WAIT cycle of a read.
        @(posedge clk);
        #1;
        cmp_on = 1'b0;
        rd_en = 1'b1;
        address = 32'd1040;
        $display("txn wr=0 rd=1 addr=1040 reset-abort");
        repeat (3) @(posedge clk);
        #1;
        check("abort_wait_ready", ready, 1'b0);
        rst = 1'b1;
        rd_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_ready", ready, 1'b1);
        check("abort_read_data", read_data, 32'h0);
        check("abort_we_n", sram_we_n, 1'b1);
        model_rd = '0;
        cmp_on = 1'b1;
        idle(3);

        // Zero-wait instance: 4-cycle read.
        @(posedge clk);
        #1;
        rd_en_b = 1'b1;
        address_b = 32'd1028;
        $display("txn wr=0 rd=1 addr=1028 wait_cycles=0");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("w0_ready_c%0d", i), ready_b, (i == 3) ? 1'b1 : 1'b0);
            check($sformatf("w0_we_n_c%0d", i), sram_we_n_b, 1'b1);
        end
        check("w0_read_data", read_data_b, 32'h12345678);
        @(posedge clk);
        #1;
        rd_en_b = 1'b0;
        idle(2);

        if (exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL leftover_expectations: got %0d expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
